// File: rtl/periodo_clk2_monitor.sv
// Measures period and high time of the divided clock clk2_in in clk cycles, with range/loss flags.
// Optional build macro PERIODO_PROMEDIO_EN adds a running average of the last four periods.
module periodo_clk2_monitor #(
  parameter int unsigned W       = 26,
  parameter int unsigned P_MIN   = 18,
  parameter int unsigned P_MAX   = 22,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk2_in,
  input  logic         enable,
  output logic [W-1:0] periodo,
  output logic [W-1:0] alto,
  output logic         valido,
  output logic         fuera_rango,
  output logic         sin_senal
`ifdef PERIODO_PROMEDIO_EN
  ,
  output logic [W-1:0] promedio
`endif
);

  typedef enum logic [1:0] {StIdle, StEspera, StMide} state_e;

  localparam logic [W-1:0] CntMax = '1;
  localparam logic [W-1:0] One    = W'(1);
  localparam logic [W-1:0] PMin   = W'(P_MIN);
  localparam logic [W-1:0] PMax   = W'(P_MAX);
  localparam logic [W-1:0] Tmo    = W'(TIMEOUT);

  state_e         state_q;
  logic           s1_q, s2_q, s3_q;
  logic [W-1:0]   cnt_q, cnt_alto_q;
  logic [W-1:0]   periodo_q, alto_q;
  logic           valido_q, fuera_rango_q, sin_senal_q;
  logic           rise;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == CntMax) ? v : v + One;
  endfunction

  assign rise = s2_q & ~s3_q;

`ifdef PERIODO_PROMEDIO_EN
  // The period being committed is the fourth entry; the history keeps the three before it.
  logic [2:0][W-1:0] hist_q;
  logic [2:0]        n_q;
  logic [W-1:0]      promedio_q;
  logic [W+1:0]      suma;

  always_comb begin
    suma = (W+2)'(cnt_q) + (W+2)'(hist_q[0]) + (W+2)'(hist_q[1]) + (W+2)'(hist_q[2]);
  end

  assign promedio = promedio_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      cnt_q         <= '0;
      cnt_alto_q    <= '0;
      periodo_q     <= '0;
      alto_q        <= '0;
      valido_q      <= 1'b0;
      fuera_rango_q <= 1'b0;
      sin_senal_q   <= 1'b0;
`ifdef PERIODO_PROMEDIO_EN
      hist_q        <= '0;
      n_q           <= '0;
      promedio_q    <= '0;
`endif
    end else begin
      s1_q     <= clk2_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      valido_q <= 1'b0;
      if (!enable) begin
        // Disabling discards any measurement in progress, even on an edge cycle.
        state_q    <= StIdle;
        cnt_q      <= '0;
        cnt_alto_q <= '0;
`ifdef PERIODO_PROMEDIO_EN
        hist_q     <= '0;
        n_q        <= '0;
        promedio_q <= '0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StEspera;
          end
          StEspera: begin
            if (rise) begin
              cnt_q      <= One;
              cnt_alto_q <= One;
              state_q    <= StMide;
            end else if (cnt_q >= Tmo) begin
              sin_senal_q <= 1'b1;
              cnt_q       <= '0;
            end else begin
              cnt_q <= sat_inc(cnt_q);
            end
          end
          StMide: begin
            if (rise) begin
              periodo_q     <= cnt_q;
              alto_q        <= cnt_alto_q;
              fuera_rango_q <= (cnt_q < PMin) || (cnt_q > PMax);
              valido_q      <= 1'b1;
              sin_senal_q   <= 1'b0;
              cnt_q         <= One;
              cnt_alto_q    <= One;
`ifdef PERIODO_PROMEDIO_EN
              hist_q <= {hist_q[1:0], cnt_q};
              if (n_q >= 3'd3) begin
                promedio_q <= suma[W+1:2];
              end
              if (n_q < 3'd4) begin
                n_q <= n_q + 3'd1;
              end
`endif
            end else if (cnt_q >= Tmo) begin
              sin_senal_q <= 1'b1;
              cnt_q       <= '0;
              cnt_alto_q  <= '0;
              state_q     <= StEspera;
`ifdef PERIODO_PROMEDIO_EN
              hist_q      <= '0;
              n_q         <= '0;
              promedio_q  <= '0;
`endif
            end else begin
              cnt_q <= sat_inc(cnt_q);
              if (s2_q) begin
                cnt_alto_q <= sat_inc(cnt_alto_q);
              end
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign periodo     = periodo_q;
  assign alto        = alto_q;
  assign valido      = valido_q;
  assign fuera_rango = fuera_rango_q;
  assign sin_senal   = sin_senal_q;

endmodule
